// File: rtl/mul_mod2nm1_seq_if.sv
// Handshake bundle for the sequential mod (2^width - 1) multiplier.
// Ports: InValid/InReady/A/B carry the operand pair in; OutValid/OutReady/P
// carry the product out; Busy reports that a product is in flight or held.
interface mul_mod2nm1_seq_if #(
    parameter int width = 8
);
    logic             InValid;
    logic             InReady;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic             OutValid;
    logic             OutReady;
    logic [width-1:0] P;
    logic             Busy;

    // master: the operand producer / result consumer side
    modport master (
        output InValid, A, B, OutReady,
        input  InReady, OutValid, P, Busy
    );

    // slave: the multiplier itself
    modport slave (
        input  InValid, A, B, OutReady,
        output InReady, OutValid, P, Busy
    );
endinterface

// File: rtl/mul_mod2nm1_seq.sv
// Sequential multiplier P = A*B mod (2^width - 1), single-zero result, one B bit per cycle (MSB first).
// Latency: OutValid rises width+1 edges after acceptance (1 edge with MULMOD_EARLY_EXIT_EN on trivial operands).
// Backpressure: InReady only in IDLE; DONE holds OutValid/P stable until OutReady.
// Ports: CLK, RST (async, active-high), bus (mul_mod2nm1_seq_if.slave).
// Optional build macro: MULMOD_EARLY_EXIT_EN skips the bit-serial loop when A or B is a zero encoding.

package lau_pkg;
    typedef enum logic {FAST, SMALL} speed_t;
endpackage

// Combinational end-around-carry adder mod (2^width - 1), result never all-ones.
// FAST precomputes a+b and a+b+1 and selects; SMALL feeds the carry back in series.
module AddMod2Nm1s0 #(
    parameter int              width = 8,
    parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] S
);
    logic [width:0]   s0;
    logic [width-1:0] raw;

    assign s0 = {1'b0, A} + {1'b0, B};

    generate
        if (speed == lau_pkg::FAST) begin : g_fast
            logic [width:0] s1;
            assign s1  = s0 + (width+1)'(1);
            // a+b >= 2^width-1 exactly when a+b+1 carries out
            assign raw = s1[width] ? s1[width-1:0] : s0[width-1:0];
        end else begin : g_small
            assign raw = s0[width-1:0] + {{(width-1){1'b0}}, s0[width]};
        end
    endgenerate

    // fold the all-ones encoding of zero onto 0
    assign S = (&raw) ? '0 : raw;
endmodule

module mul_mod2nm1_seq #(
    parameter int              width = 8,
    parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
    input  logic                  CLK,
    input  logic                  RST,
    mul_mod2nm1_seq_if.slave      bus
);
    localparam int CW = (width > 2) ? $clog2(width) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] acc, a_reg, b_reg;
    logic [CW-1:0]    cnt;
    logic [width-1:0] rot, addend, sum;
    logic             accept;
    logic             skip;

    assign accept = (state_q == IDLE) && bus.InValid;

`ifdef MULMOD_EARLY_EXIT_EN
    // a zero (0 or all-ones) operand makes the product 0 without iterating
    assign skip = (bus.A == '0) || (&bus.A) || (bus.B == '0) || (&bus.B);
`else
    assign skip = 1'b0;
`endif

    // acc is never all-ones, so the rotate (x2 mod 2^width-1) never is either
    assign rot    = {acc[width-2:0], acc[width-1]};
    assign addend = b_reg[cnt] ? a_reg : '0;

    AddMod2Nm1s0 #(
        .width (width),
        .speed (speed)
    ) u_add (
        .A (rot),
        .B (addend),
        .S (sum)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.InValid) state_d = skip ? DONE : BUSY;
            BUSY: if (cnt == '0) state_d = DONE;
            DONE: if (bus.OutReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            acc   <= '0;
            cnt   <= CW'(width - 1);
        end else if (state_q == BUSY) begin
            acc <= sum;
            cnt <= cnt - 1'b1;
        end
    end

    assign bus.InReady  = (state_q == IDLE);
    assign bus.OutValid = (state_q == DONE);
    assign bus.Busy     = (state_q != IDLE);
    assign bus.P        = acc;
endmodule
